// File: rtl/avst_pkg.sv
// Shared Avalon-ST definitions.
// Used by the packet FIFO and the width adapters.
package avst_pkg;

    localparam int AVST_CUT_THROUGH = 0;
    localparam int AVST_STORE_FWD   = 1;

    function automatic int avst_empty_w(input int dw);
        return $clog2(dw / 8);
    endfunction

endpackage

// File: rtl/avst_fifo_mem.sv
// Simple dual-port storage for the packet FIFO.
// Synchronous write, asynchronous read (distributed RAM).
module avst_fifo_mem #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk_i,
    input  logic             we_i,
    input  logic [AW-1:0]    waddr_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic [AW-1:0]    raddr_i,
    output logic [WIDTH-1:0] rdata_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    // Store one beat per accepted write; contents are never reset.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/avst_pkt_fifo.sv
// Avalon-ST FIFO with optional store-and-forward mode.
// Exports fill level, packet count and a sticky framing flag.
module avst_pkt_fifo
    import avst_pkg::*;
#(
    parameter int DATA_WIDTH    = 32,
    parameter int ERROR_WIDTH   = 1,
    parameter int DEPTH         = 16,
    parameter int STORE_FORWARD = 0
) (
    input  logic                                Clk_CI,
    input  logic                                Rst_RBI,
    output logic                                SnkReady_SO,
    input  logic                                SnkValid_SI,
    input  logic                                SnkSop_SI,
    input  logic                                SnkEop_SI,
    input  logic [avst_empty_w(DATA_WIDTH)-1:0] SnkEmpty_SI,
    input  logic [ERROR_WIDTH-1:0]              SnkError_SI,
    input  logic [DATA_WIDTH-1:0]               SnkData_DI,
    input  logic                                SrcReady_SI,
    output logic                                SrcValid_SO,
    output logic                                SrcSop_SO,
    output logic                                SrcEop_SO,
    output logic [avst_empty_w(DATA_WIDTH)-1:0] SrcEmpty_SO,
    output logic [ERROR_WIDTH-1:0]              SrcError_SO,
    output logic [DATA_WIDTH-1:0]               SrcData_DO,
    output logic [$clog2(DEPTH):0]              Fill_DO,
    output logic [$clog2(DEPTH):0]              PktCnt_DO,
    output logic                                FramingErr_SO
);

    localparam int EMPTY_WIDTH = avst_empty_w(DATA_WIDTH);
    localparam int AW = $clog2(DEPTH);
    localparam int MW = DATA_WIDTH + ERROR_WIDTH + EMPTY_WIDTH + 2;
    localparam logic [AW:0] FULL = (AW + 1)'(DEPTH);
    localparam logic [AW:0] ONE = (AW + 1)'(1);
    localparam logic [AW-1:0] PTR_ONE = AW'(1);

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   fill_q, fill_d;
    logic [AW:0]   pkt_q, pkt_d;
    logic          ready_q, ready_d;
    logic          in_pkt_q, in_pkt_d;
    logic          ferr_q, ferr_d;
    logic          out_pkt_q, out_pkt_d;

    logic          wr_en;
    logic          rd_en;
    logic          src_valid;
    logic          rd_eop;
    logic [MW-1:0] wr_word;
    logic [MW-1:0] rd_word;

    assign wr_word = {SnkSop_SI, SnkEop_SI, SnkEmpty_SI,
                      SnkError_SI, SnkData_DI};

    avst_fifo_mem #(
        .WIDTH (MW),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clk_i   (Clk_CI),
        .we_i    (wr_en),
        .waddr_i (wr_ptr_q),
        .wdata_i (wr_word),
        .raddr_i (rd_ptr_q),
        .rdata_o (rd_word)
    );

    assign SrcData_DO  = rd_word[DATA_WIDTH-1:0];
    assign SrcError_SO = rd_word[DATA_WIDTH +: ERROR_WIDTH];
    assign SrcEmpty_SO = rd_word[DATA_WIDTH+ERROR_WIDTH +: EMPTY_WIDTH];
    assign rd_eop      = rd_word[MW-2];
    assign SrcEop_SO   = rd_eop;
    assign SrcSop_SO   = rd_word[MW-1];

    // Source valid: full override and open-packet hold avoid deadlock.
    always_comb begin
        src_valid = (fill_q != '0);
        if (STORE_FORWARD == AVST_STORE_FWD) begin
            src_valid = (fill_q != '0) &
                        ((pkt_q != '0) | (fill_q == FULL) | out_pkt_q);
        end
    end

    assign SrcValid_SO = src_valid;
    assign wr_en = SnkValid_SI & ready_q;
    assign rd_en = src_valid & SrcReady_SI;

    // Next-state for pointers, counters, ready and framing tracker.
    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        fill_d    = fill_q;
        pkt_d     = pkt_q;
        in_pkt_d  = in_pkt_q;
        ferr_d    = ferr_q;
        out_pkt_d = out_pkt_q;

        if (wr_en) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end
        if (rd_en) begin
            rd_ptr_d  = rd_ptr_q + PTR_ONE;
            out_pkt_d = ~rd_eop;
        end

        case ({wr_en, rd_en})
            2'b10:   fill_d = fill_q + ONE;
            2'b01:   fill_d = fill_q - ONE;
            default: fill_d = fill_q;
        endcase

        case ({wr_en & SnkEop_SI, rd_en & rd_eop})
            2'b10:   pkt_d = pkt_q + ONE;
            2'b01:   pkt_d = pkt_q - ONE;
            default: pkt_d = pkt_q;
        endcase

        if (wr_en) begin
            if (SnkSop_SI & in_pkt_q) begin
                ferr_d = 1'b1;
            end
            if (~SnkSop_SI & ~in_pkt_q) begin
                ferr_d = 1'b1;
            end
            if (SnkEop_SI) begin
                in_pkt_d = 1'b0;
            end else if (SnkSop_SI) begin
                in_pkt_d = 1'b1;
            end
        end

        ready_d = (fill_d != FULL);
    end

    // State registers, all cleared asynchronously.
    always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
        if (!Rst_RBI) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            fill_q    <= '0;
            pkt_q     <= '0;
            ready_q   <= 1'b0;
            in_pkt_q  <= 1'b0;
            ferr_q    <= 1'b0;
            out_pkt_q <= 1'b0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            fill_q    <= fill_d;
            pkt_q     <= pkt_d;
            ready_q   <= ready_d;
            in_pkt_q  <= in_pkt_d;
            ferr_q    <= ferr_d;
            out_pkt_q <= out_pkt_d;
        end
    end

    assign SnkReady_SO   = ready_q;
    assign Fill_DO       = fill_q;
    assign PktCnt_DO     = pkt_q;
    assign FramingErr_SO = ferr_q;

endmodule

// File: tb/tb_avst_pkt_fifo.sv
// Scoreboard bench for avst_pkt_fifo.
// One cut-through and one store-and-forward instance.
module tb_avst_pkt_fifo;

    logic clk;
    int checks;
    int errors;

    logic        c_rst, c_vld, c_sop, c_eop, c_err, c_rdy, c_srdy;
    logic [1:0]  c_emp;
    logic [31:0] c_dat;
    logic        c_ov, c_osop, c_oeop, c_oerr, c_ferr;
    logic [1:0]  c_oemp;
    logic [31:0] c_odat;
    logic [4:0]  c_fill, c_pkt;

    logic        s_rst, s_vld, s_sop, s_eop, s_err, s_rdy, s_srdy;
    logic [1:0]  s_emp;
    logic [31:0] s_dat;
    logic        s_ov, s_osop, s_oeop, s_oerr, s_ferr;
    logic [1:0]  s_oemp;
    logic [31:0] s_odat;
    logic [4:0]  s_fill, s_pkt;

    logic [36:0] c_q[$];
    logic [36:0] s_q[$];
    logic [31:0] t1 [3];

    avst_pkt_fifo #(
        .DATA_WIDTH(32), .ERROR_WIDTH(1), .DEPTH(16), .STORE_FORWARD(0)
    ) u_ct (
        .Clk_CI(clk), .Rst_RBI(c_rst), .SnkReady_SO(c_rdy),
        .SnkValid_SI(c_vld), .SnkSop_SI(c_sop), .SnkEop_SI(c_eop),
        .SnkEmpty_SI(c_emp), .SnkError_SI(c_err), .SnkData_DI(c_dat),
        .SrcReady_SI(c_srdy), .SrcValid_SO(c_ov), .SrcSop_SO(c_osop),
        .SrcEop_SO(c_oeop), .SrcEmpty_SO(c_oemp), .SrcError_SO(c_oerr),
        .SrcData_DO(c_odat), .Fill_DO(c_fill), .PktCnt_DO(c_pkt),
        .FramingErr_SO(c_ferr)
    );

    avst_pkt_fifo #(
        .DATA_WIDTH(32), .ERROR_WIDTH(1), .DEPTH(16), .STORE_FORWARD(1)
    ) u_sf (
        .Clk_CI(clk), .Rst_RBI(s_rst), .SnkReady_SO(s_rdy),
        .SnkValid_SI(s_vld), .SnkSop_SI(s_sop), .SnkEop_SI(s_eop),
        .SnkEmpty_SI(s_emp), .SnkError_SI(s_err), .SnkData_DI(s_dat),
        .SrcReady_SI(s_srdy), .SrcValid_SO(s_ov), .SrcSop_SO(s_osop),
        .SrcEop_SO(s_oeop), .SrcEmpty_SO(s_oemp), .SrcError_SO(s_oerr),
        .SrcData_DO(s_odat), .Fill_DO(s_fill), .PktCnt_DO(s_pkt),
        .FramingErr_SO(s_ferr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Drive one beat; push the expected output on the accepting edge.
    task automatic put(input bit sf, input logic sop, input logic eop,
                       input logic [1:0] emp, input logic [31:0] d);
        int n;
        n = 0;
        if (sf) begin
            s_vld = 1; s_sop = sop; s_eop = eop; s_emp = emp;
            s_err = d[0]; s_dat = d;
        end else begin
            c_vld = 1; c_sop = sop; c_eop = eop; c_emp = emp;
            c_err = d[0]; c_dat = d;
        end
        while (!(sf ? s_rdy : c_rdy) && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!(sf ? s_rdy : c_rdy)) begin
            checks++;
            errors++;
            $display("FAIL put_timeout: got ready 0 expected 1 (sf=%0d)", sf);
        end else begin
            @(posedge clk);
            if (sf) s_q.push_back({sop, eop, emp, d[0], d});
            else    c_q.push_back({sop, eop, emp, d[0], d});
        end
        @(negedge clk);
        if (sf) s_vld = 0;
        else    c_vld = 0;
    endtask

    task automatic wait_empty(input bit sf, input string nm);
        int n;
        n = 0;
        while ((sf ? s_fill : c_fill) != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk(nm, int'(sf ? s_fill : c_fill), 0);
    endtask

    // Monitor: pop and compare every beat the source hands over.
    always @(negedge clk) begin : mon
        logic [36:0] a;
        logic [36:0] e;
        #1;
        if (c_rst && c_ov && c_srdy) begin
            checks++;
            a = {c_osop, c_oeop, c_oemp, c_oerr, c_odat};
            if (c_q.size() == 0) begin
                errors++;
                $display("FAIL ct_unexpected: got %h expected none", a);
            end else begin
                e = c_q.pop_front();
                if (a !== e) begin
                    errors++;
                    $display("FAIL ct_beat: got %h expected %h", a, e);
                end
            end
        end
        if (s_rst && s_ov && s_srdy) begin
            checks++;
            a = {s_osop, s_oeop, s_oemp, s_oerr, s_odat};
            if (s_q.size() == 0) begin
                errors++;
                $display("FAIL sf_unexpected: got %h expected none", a);
            end else begin
                e = s_q.pop_front();
                if (a !== e) begin
                    errors++;
                    $display("FAIL sf_beat: got %h expected %h", a, e);
                end
            end
        end
    end

    initial begin
        checks = 0;
        errors = 0;
        t1[0] = 32'h11; t1[1] = 32'h22; t1[2] = 32'h33;
        c_rst = 0; c_vld = 0; c_sop = 0; c_eop = 0; c_emp = 0;
        c_err = 0; c_dat = 0; c_srdy = 0;
        s_rst = 0; s_vld = 0; s_sop = 0; s_eop = 0; s_emp = 0;
        s_err = 0; s_dat = 0; s_srdy = 0;

        repeat (2) @(negedge clk);
        chk("rst_ct_ready", c_rdy, 0);
        chk("rst_ct_valid", c_ov, 0);
        chk("rst_ct_fill", c_fill, 0);
        chk("rst_ct_pkt", c_pkt, 0);
        chk("rst_ct_ferr", c_ferr, 0);
        chk("rst_sf_ready", s_rdy, 0);
        chk("rst_sf_valid", s_ov, 0);
        c_rst = 1;
        s_rst = 1;
        #1;
        chk("ct_ready_before_edge", c_rdy, 0);
        @(negedge clk);
        chk("ct_ready_after_edge", c_rdy, 1);
        chk("sf_ready_after_edge", s_rdy, 1);

        // Cut-through single-beat packets, sink always ready.
        c_srdy = 1;
        for (int i = 0; i < 3; i++) begin
            put(0, 1, 1, 2'd0, t1[i]);
            chk("ct1_valid", c_ov, 1);
            chk("ct1_fill", c_fill, 1);
        end
        @(negedge clk);
        chk("ct1_fill_end", c_fill, 0);
        chk("ct1_pkt_end", c_pkt, 0);
        chk("ct1_valid_end", c_ov, 0);

        // Fill to full with the sink stalled.
        c_srdy = 0;
        for (int i = 0; i < 16; i++) begin
            put(0, i == 0, i == 15, 2'd0, 32'h100 + i);
            if (i == 14) begin
                chk("ct2_ready_15", c_rdy, 1);
                chk("ct2_fill_15", c_fill, 15);
            end
        end
        chk("ct2_ready_full", c_rdy, 0);
        chk("ct2_fill_full", c_fill, 16);
        chk("ct2_pkt_full", c_pkt, 1);
        c_srdy = 1;
        @(negedge clk);
        c_srdy = 0;
        chk("ct2_fill_after_read", c_fill, 15);
        chk("ct2_ready_after_read", c_rdy, 1);
        c_srdy = 1;
        wait_empty(0, "ct2_drain");
        chk("ct2_pkt_end", c_pkt, 0);

        // Framing: orphan beat, then sop, then sop again.
        chk("fr_ferr_before", c_ferr, 0);
        put(0, 0, 0, 2'd0, 32'hA1);
        chk("fr_ferr_orphan", c_ferr, 1);
        put(0, 1, 0, 2'd0, 32'hA2);
        chk("fr_ferr_sticky", c_ferr, 1);
        put(0, 1, 1, 2'd1, 32'hA3);
        chk("fr_ferr_dup_sop", c_ferr, 1);
        wait_empty(0, "fr_drain");
        chk("fr_ferr_end", c_ferr, 1);

        // Asynchronous reset in the middle of a packet.
        c_srdy = 0;
        put(0, 1, 0, 2'd0, 32'h501);
        put(0, 0, 0, 2'd0, 32'h502);
        put(0, 0, 0, 2'd0, 32'h503);
        chk("rp_fill_before", c_fill, 3);
        #2;
        c_rst = 0;
        #1;
        chk("rp_fill_in_rst", c_fill, 0);
        chk("rp_valid_in_rst", c_ov, 0);
        chk("rp_ready_in_rst", c_rdy, 0);
        chk("rp_ferr_in_rst", c_ferr, 0);
        c_q.delete();
        @(negedge clk);
        c_rst = 1;
        @(negedge clk);
        chk("rp_ready_release", c_rdy, 1);
        chk("rp_valid_release", c_ov, 0);
        c_srdy = 1;
        repeat (5) @(negedge clk);
        chk("rp_no_stale", c_ov, 0);
        put(0, 1, 1, 2'd3, 32'h77);
        wait_empty(0, "rp_fresh_drain");
        chk("rp_ferr_fresh", c_ferr, 0);

        // Store-and-forward: 5-beat packet held until eop.
        s_srdy = 1;
        for (int i = 0; i < 5; i++) begin
            put(1, i == 0, i == 4, (i == 4) ? 2'd2 : 2'd0, 32'h200 + i);
            if (i < 4) begin
                chk("sf1_hold", s_ov, 0);
            end else begin
                chk("sf1_valid_after_eop", s_ov, 1);
                chk("sf1_pkt_one", s_pkt, 1);
            end
        end
        wait_empty(1, "sf1_drain");
        chk("sf1_pkt_end", s_pkt, 0);

        // Store-and-forward: 20-beat packet overflows depth.
        for (int i = 0; i < 20; i++) begin
            put(1, i == 0, i == 19, 2'd0, 32'h300 + i);
            if (i == 14) begin
                chk("sf2_hold_15", s_ov, 0);
            end
            if (i == 15) begin
                chk("sf2_valid_full", s_ov, 1);
                chk("sf2_pkt_full", s_pkt, 0);
                chk("sf2_fill_full", s_fill, 16);
            end
        end
        wait_empty(1, "sf2_drain");
        chk("sf2_pkt_end", s_pkt, 0);
        chk("sf2_ferr", s_ferr, 0);

        repeat (3) @(negedge clk);
        chk("ct_queue_left", c_q.size(), 0);
        chk("sf_queue_left", s_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
